// File: rtl/program_sequencer_if.sv
// Fetch-side bundle between the program sequencer and the rest of the core:
// decoder/ALU control into the sequencer, fetch address and debug taps out.
interface program_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8
);
    logic              jmp;
    logic              jmp_nz;
    logic [3:0]        ir_nibble;
    logic              dont_jmp;
    logic              hold;
    logic [ADDR_W-1:0] pm_addr;
    logic [ADDR_W-1:0] pc;
    logic [1:0]        state_o;
    logic              jmp_taken;
    logic              wrap;
    logic [CNT_W-1:0]  jmp_count;
    logic [CNT_W-1:0]  stall_count;
    logic [7:0]        from_PS;

    // Sequencer side: consumes control, produces address and status.
    modport master (
        input  jmp, jmp_nz, ir_nibble, dont_jmp, hold,
        output pm_addr, pc, state_o, jmp_taken, wrap,
               jmp_count, stall_count, from_PS
    );

    // Core side: drives control, observes address and status.
    modport slave (
        output jmp, jmp_nz, ir_nibble, dont_jmp, hold,
        input  pm_addr, pc, state_o, jmp_taken, wrap,
               jmp_count, stall_count, from_PS
    );
endinterface

// File: rtl/program_sequencer.sv
// Program sequencer: produces the program-memory fetch address for the 8-bit
// core. pm_addr feeds the asynchronous program-memory read port; the decoder
// captures the read data into ir on the same edge that pc captures pm_addr,
// so pc always names the instruction sitting in ir and jumps cost no bubble.
module program_sequencer #(
    parameter int                ADDR_W       = 8,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = {ADDR_W{1'b0}},
    parameter int                CNT_W        = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    program_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        ST_RESET_FETCH = 2'd0,
        ST_RUN         = 2'd1,
        ST_HOLD        = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONES = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ONES  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state_r;
    logic [ADDR_W-1:0] pc_r;
    logic              wrap_r;
    logic [CNT_W-1:0]  jmp_count_r;
    logic [CNT_W-1:0]  stall_count_r;

    logic [ADDR_W-1:0] pc_inc_s;
    logic [ADDR_W-1:0] target_s;
    logic [ADDR_W-1:0] next_addr_s;
    logic              jump_req_s;
    logic              take_s;
    logic              inc_sel_s;

    // Jump targets are page-aligned: the ir nibble selects the top 4 bits.
    assign pc_inc_s   = pc_r + ADDR_ONE;
    assign target_s   = {bus.ir_nibble, {(ADDR_W-4){1'b0}}};
    // jmp dominates; jmp_nz is gated by the ALU zero flag only.
    assign jump_req_s = bus.jmp | (bus.jmp_nz & ~bus.dont_jmp);
    // Jumps only count once ir holds a valid instruction and fetch is not held.
    assign take_s     = jump_req_s & (state_r == ST_RUN) & ~bus.hold;

    // Fetch address select; HOLD keeps refetching pc (including its exit
    // cycle) so a jump parked in ir survives the stall and fires in RUN.
    always_comb begin
        next_addr_s = pc_r;
        inc_sel_s   = 1'b0;
        if (!reset_n) begin
            next_addr_s = RESET_VECTOR;
        end else begin
            case (state_r)
                ST_RESET_FETCH: begin
                    next_addr_s = RESET_VECTOR;
                end
                ST_RUN: begin
                    if (bus.hold) begin
                        next_addr_s = pc_r;
                    end else if (take_s) begin
                        next_addr_s = target_s;
                    end else begin
                        next_addr_s = pc_inc_s;
                        inc_sel_s   = 1'b1;
                    end
                end
                ST_HOLD: begin
                    next_addr_s = pc_r;
                end
                default: begin
                    next_addr_s = RESET_VECTOR;
                end
            endcase
        end
    end

    // FSM, program counter, wrap pulse and saturating debug counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_RESET_FETCH;
            pc_r          <= RESET_VECTOR;
            wrap_r        <= 1'b0;
            jmp_count_r   <= {CNT_W{1'b0}};
            stall_count_r <= {CNT_W{1'b0}};
        end else begin
            pc_r   <= next_addr_s;
            // Only a natural roll-over counts; a jump to 0 is not a wrap.
            wrap_r <= inc_sel_s & (pc_r == ADDR_ONES);

            if (take_s && (jmp_count_r != CNT_ONES)) begin
                jmp_count_r <= jmp_count_r + CNT_ONE;
            end else begin
                jmp_count_r <= jmp_count_r;
            end

            if ((state_r == ST_HOLD) && (stall_count_r != CNT_ONES)) begin
                stall_count_r <= stall_count_r + CNT_ONE;
            end else begin
                stall_count_r <= stall_count_r;
            end

            case (state_r)
                ST_RESET_FETCH: state_r <= ST_RUN;
                ST_RUN:         state_r <= bus.hold ? ST_HOLD : ST_RUN;
                ST_HOLD:        state_r <= bus.hold ? ST_HOLD : ST_RUN;
                default:        state_r <= ST_RESET_FETCH;
            endcase
        end
    end

    assign bus.pm_addr     = next_addr_s;
    assign bus.jmp_taken   = take_s;
    assign bus.pc          = pc_r;
    assign bus.state_o     = state_r;
    assign bus.wrap        = wrap_r;
    assign bus.jmp_count   = jmp_count_r;
    assign bus.stall_count = stall_count_r;

    // Debug tap is always 8 bits regardless of address width.
    generate
        if (ADDR_W >= 8) begin : g_tap_trunc
            assign bus.from_PS = pc_r[7:0];
        end else begin : g_tap_ext
            assign bus.from_PS = {{(8-ADDR_W){1'b0}}, pc_r};
        end
    endgenerate

endmodule

// File: tb/tb_program_sequencer.sv
// Directed testbench for program_sequencer (ADDR_W=8, RESET_VECTOR=0, CNT_W=8).
module tb_program_sequencer;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_errors;

    program_sequencer_if #(.ADDR_W(8), .CNT_W(8)) bus ();

    program_sequencer #(.ADDR_W(8), .RESET_VECTOR(8'h00), .CNT_W(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        reset_n       = 1'b0;
        bus.jmp       = 1'b0;
        bus.jmp_nz    = 1'b0;
        bus.ir_nibble = 4'h0;
        bus.dont_jmp  = 1'b0;
        bus.hold      = 1'b0;

        // Reset state
        tick();
        tick();
        check_val("rst_state", 32'(bus.state_o), 32'd0);
        check_val("rst_pc", 32'(bus.pc), 32'h00);
        check_val("rst_pm_addr", 32'(bus.pm_addr), 32'h00);
        check_val("rst_wrap", 32'(bus.wrap), 32'd0);
        check_val("rst_jcnt", 32'(bus.jmp_count), 32'd0);
        check_val("rst_scnt", 32'(bus.stall_count), 32'd0);

        // Release: RESET_FETCH then sequential fetch
        reset_n = 1'b1;
        #1;
        check_val("rf_pm_addr", 32'(bus.pm_addr), 32'h00);
        check_val("rf_state", 32'(bus.state_o), 32'd0);
        tick();
        check_val("run_state", 32'(bus.state_o), 32'd1);
        check_val("run_pc0", 32'(bus.pc), 32'h00);
        check_val("run_pm1", 32'(bus.pm_addr), 32'h01);
        tick();
        check_val("run_pm2", 32'(bus.pm_addr), 32'h02);
        tick();
        check_val("run_pm3", 32'(bus.pm_addr), 32'h03);
        tick();
        tick();
        tick();
        check_val("run_pc5", 32'(bus.pc), 32'h05);

        // Unconditional jump to 0x30
        bus.jmp = 1'b1; bus.ir_nibble = 4'h3;
        #1;
        check_val("jmp_pm", 32'(bus.pm_addr), 32'h30);
        check_val("jmp_taken", 32'(bus.jmp_taken), 32'd1);
        tick();
        bus.jmp = 1'b0;
        check_val("jmp_pc", 32'(bus.pc), 32'h30);
        check_val("jmp_cnt1", 32'(bus.jmp_count), 32'd1);

        // Conditional jump suppressed, then taken
        bus.jmp_nz = 1'b1; bus.ir_nibble = 4'h7; bus.dont_jmp = 1'b1;
        #1;
        check_val("jnz_supp_pm", 32'(bus.pm_addr), 32'h31);
        check_val("jnz_supp_tk", 32'(bus.jmp_taken), 32'd0);
        tick();
        check_val("jnz_supp_cnt", 32'(bus.jmp_count), 32'd1);
        bus.dont_jmp = 1'b0;
        #1;
        check_val("jnz_pm", 32'(bus.pm_addr), 32'h70);
        tick();
        bus.jmp_nz = 1'b0;
        check_val("jnz_pc", 32'(bus.pc), 32'h70);
        check_val("jnz_cnt", 32'(bus.jmp_count), 32'd2);

        // Get to 0x10, then hold 3 cycles with a jump pending
        bus.jmp = 1'b1; bus.ir_nibble = 4'h1;
        tick();
        check_val("h_pc10", 32'(bus.pc), 32'h10);
        bus.ir_nibble = 4'h2; bus.hold = 1'b1;
        #1;
        check_val("h_first_pm", 32'(bus.pm_addr), 32'h10);
        check_val("h_first_tk", 32'(bus.jmp_taken), 32'd0);
        tick();
        check_val("h_state", 32'(bus.state_o), 32'd2);
        check_val("h_pm_a", 32'(bus.pm_addr), 32'h10);
        tick();
        check_val("h_pm_b", 32'(bus.pm_addr), 32'h10);
        tick();
        check_val("h_scnt2", 32'(bus.stall_count), 32'd2);
        bus.hold = 1'b0;
        #1;
        check_val("h_exit_pm", 32'(bus.pm_addr), 32'h10);
        check_val("h_exit_tk", 32'(bus.jmp_taken), 32'd0);
        tick();
        check_val("h_run_state", 32'(bus.state_o), 32'd1);
        check_val("h_scnt3", 32'(bus.stall_count), 32'd3);
        check_val("h_def_pm", 32'(bus.pm_addr), 32'h20);
        check_val("h_def_tk", 32'(bus.jmp_taken), 32'd1);
        tick();
        check_val("h_def_pc", 32'(bus.pc), 32'h20);
        check_val("h_def_cnt", 32'(bus.jmp_count), 32'd4);

        // Wrap 0xFF -> 0x00
        bus.ir_nibble = 4'hF;
        tick();
        bus.jmp = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        check_val("w_pcff", 32'(bus.pc), 32'hFF);
        check_val("w_pre", 32'(bus.wrap), 32'd0);
        tick();
        check_val("w_pc0", 32'(bus.pc), 32'h00);
        check_val("w_pulse", 32'(bus.wrap), 32'd1);
        tick();
        check_val("w_clear", 32'(bus.wrap), 32'd0);

        // Jump to nibble 0 from 0x42: no wrap
        bus.jmp = 1'b1; bus.ir_nibble = 4'h4;
        tick();
        bus.jmp = 1'b0;
        tick();
        tick();
        check_val("j0_pc42", 32'(bus.pc), 32'h42);
        check_val("j0_tap", 32'(bus.from_PS), 32'h42);
        bus.jmp = 1'b1; bus.ir_nibble = 4'h0;
        #1;
        check_val("j0_pm", 32'(bus.pm_addr), 32'h00);
        tick();
        check_val("j0_pc", 32'(bus.pc), 32'h00);
        check_val("j0_wrap", 32'(bus.wrap), 32'd0);
        check_val("j0_cnt", 32'(bus.jmp_count), 32'd7);

        // 300 taken jumps: counter saturates
        bus.ir_nibble = 4'h5;
        for (int i = 0; i < 300; i++) tick();
        check_val("sat_cnt", 32'(bus.jmp_count), 32'hFF);
        check_val("sat_pc", 32'(bus.pc), 32'h50);
        bus.jmp = 1'b0;

        // Reset asserted mid-HOLD
        bus.hold = 1'b1;
        tick();
        tick();
        check_val("mh_state", 32'(bus.state_o), 32'd2);
        check_val("mh_scnt", 32'(bus.stall_count), 32'd4);
        reset_n = 1'b0;
        #1;
        check_val("ar_state", 32'(bus.state_o), 32'd0);
        check_val("ar_pc", 32'(bus.pc), 32'h00);
        check_val("ar_pm", 32'(bus.pm_addr), 32'h00);
        check_val("ar_jcnt", 32'(bus.jmp_count), 32'd0);
        check_val("ar_scnt", 32'(bus.stall_count), 32'd0);
        bus.hold = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        check_val("ar_run", 32'(bus.state_o), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
        $finish;
    end

endmodule
